alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 130 +++++++++++++
 tb/tb_alu_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared single-cycle ALU.
// One transaction in flight: accept in IDLE, drive the ALU in EXEC, hold the result in RESP.
module alu_arbiter #(
  parameter logic RR_INIT = 1'b1,
  localparam int unsigned DATA_W = 32,
  localparam int unsigned OP_W = 2,
  localparam int unsigned FUNCT_W = 6
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0_valid,
  input  logic               req1_valid,
  output logic               req0_ready,
  output logic               req1_ready,
  input  logic [DATA_W-1:0]  req0_a,
  input  logic [DATA_W-1:0]  req0_b,
  input  logic [DATA_W-1:0]  req1_a,
  input  logic [DATA_W-1:0]  req1_b,
  input  logic [OP_W-1:0]    req0_op,
  input  logic [OP_W-1:0]    req1_op,
  input  logic [FUNCT_W-1:0] req0_funct,
  input  logic [FUNCT_W-1:0] req1_funct,
  output logic [DATA_W-1:0]  alu_a,
  output logic [DATA_W-1:0]  alu_b,
  output logic [OP_W-1:0]    alu_op,
  output logic [FUNCT_W-1:0] alu_funct,
  input  logic [DATA_W-1:0]  alu_result,
  input  logic               alu_zero,
  output logic               rsp0_valid,
  output logic               rsp1_valid,
  input  logic               rsp0_ready,
  input  logic               rsp1_ready,
  output logic [DATA_W-1:0]  rsp_data,
  output logic               rsp_zero,
  output logic               busy,
  output logic               grant_id
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  logic   last_grant;

  logic               any_valid;
  logic               win_id;
  logic               accept;
  logic               rsp_done;
  logic [DATA_W-1:0]  sel_a;
  logic [DATA_W-1:0]  sel_b;
  logic [OP_W-1:0]    sel_op;
  logic [FUNCT_W-1:0] sel_funct;

  // Winner selection: a lone requester wins; on a tie the one not granted last wins.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    win_id    = 1'b0;
    if (req0_valid && req1_valid) begin
      win_id = ~last_grant;
    end else if (req1_valid) begin
      win_id = 1'b1;
    end
    accept     = reset & (state == IDLE) & any_valid;
    req0_ready = accept & ~win_id;
    req1_ready = accept & win_id;
    sel_a      = win_id ? req1_a : req0_a;
    sel_b      = win_id ? req1_b : req0_b;
    sel_op     = win_id ? req1_op : req0_op;
    sel_funct  = win_id ? req1_funct : req0_funct;
    rsp_done   = grant_id ? rsp1_ready : rsp0_ready;
  end

  // Transaction FSM; reset wins over any in-flight operation and drops it silently.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= RR_INIT;
      grant_id   <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_op     <= '0;
      alu_funct  <= '0;
      rsp_data   <= '0;
      rsp_zero   <= 1'b0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            alu_a     <= sel_a;
            alu_b     <= sel_b;
            alu_op    <= sel_op;
            alu_funct <= sel_funct;
            grant_id  <= win_id;
            busy      <= 1'b1;
            state     <= EXEC;
          end
        end
        EXEC: begin
          rsp_data   <= alu_result;
          rsp_zero   <= alu_zero;
          rsp0_valid <= ~grant_id;
          rsp1_valid <= grant_id;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_done) begin
            last_grant <= grant_id;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            busy       <= 1'b0;
            state      <= IDLE;
          end
        end
        default: begin
          rsp0_valid <= 1'b0;
          rsp1_valid <= 1'b0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed cycle checks plus a response scoreboard.
// ALU stub is result = a + b, zero = (result == 0).
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic [1:0]  req0_op = '0, req1_op = '0;
  logic [5:0]  req0_funct = '0, req1_funct = '0;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [1:0]  alu_op;
  logic [5:0]  alu_funct;
  logic        alu_zero;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_zero, busy, grant_id;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic        id;
    logic [31:0] data;
    logic        zero;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  assign alu_result = alu_a + alu_b;
  assign alu_zero   = (alu_result == 32'd0);

  alu_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
    .req0_op(req0_op), .req1_op(req1_op),
    .req0_funct(req0_funct), .req1_funct(req1_funct),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_funct(alu_funct),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp0_ready(rsp0_ready), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero),
    .busy(busy), .grant_id(grant_id)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic pop_cmp(input logic id);
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_underflow", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check("rsp_id", 32'(id), 32'(e.id));
      check("rsp_data", rsp_data, e.data);
      check("rsp_zero", 32'(rsp_zero), 32'(e.zero));
    end
  endtask

  // Accept/complete monitor: push on handshake, pop and compare on response completion.
  always @(negedge clk) begin
    if (reset) begin
      if (req0_valid && req0_ready)
        sb.push_back('{id: 1'b0, data: req0_a + req0_b, zero: (req0_a + req0_b) == 32'd0});
      if (req1_valid && req1_ready)
        sb.push_back('{id: 1'b1, data: req1_a + req1_b, zero: (req1_a + req1_b) == 32'd0});
      if (rsp0_valid && rsp1_valid)
        check("rsp_onehot", 32'd1, 32'd0);
      if (rsp0_valid && rsp0_ready) pop_cmp(1'b0);
      if (rsp1_valid && rsp1_ready) pop_cmp(1'b1);
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    next_cycle();
    @(negedge clk);
    check("rst_ready0", 32'(req0_ready), 32'd0);
    check("rst_ready1", 32'(req1_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rsp0_valid", 32'(rsp0_valid), 32'd0);
    check("rst_rsp1_valid", 32'(rsp1_valid), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_zero", 32'(rsp_zero), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_alu_b", alu_b, 32'd0);
    sb.delete();
    next_cycle();
    reset = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    for (int i = 0; i < 8 && !done; i++) begin
      @(negedge clk);
      if (!busy) done = 1'b1;
      else next_cycle();
    end
    check("drain_idle", 32'(busy), 32'd0);
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    next_cycle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Single request on requester 0
    do_reset();
    req0_valid = 1'b1; req0_a = 32'd5; req0_b = 32'd7; req0_op = 2'd2; req0_funct = 6'h20;
    @(negedge clk);
    check("t1_ready0", 32'(req0_ready), 32'd1);
    check("t1_ready1", 32'(req1_ready), 32'd0);
    check("t1_idle", 32'(busy), 32'd0);
    next_cycle();
    req0_valid = 1'b0;
    @(negedge clk);
    check("t1_exec_busy", 32'(busy), 32'd1);
    check("t1_gid", 32'(grant_id), 32'd0);
    check("t1_alu_a", alu_a, 32'd5);
    check("t1_alu_b", alu_b, 32'd7);
    check("t1_alu_op", 32'(alu_op), 32'd2);
    check("t1_alu_funct", 32'(alu_funct), 32'h20);
    check("t1_exec_rsp0", 32'(rsp0_valid), 32'd0);
    next_cycle();
    rsp0_ready = 1'b1;
    @(negedge clk);
    check("t1_rsp0_valid", 32'(rsp0_valid), 32'd1);
    check("t1_rsp1_valid", 32'(rsp1_valid), 32'd0);
    check("t1_rsp_data", rsp_data, 32'd12);
    check("t1_rsp_zero", 32'(rsp_zero), 32'd0);
    next_cycle();
    rsp0_ready = 1'b0;
    @(negedge clk);
    check("t1_done_busy", 32'(busy), 32'd0);
    check("t1_done_rsp0", 32'(rsp0_valid), 32'd0);

    // Tie: both valid every cycle, grants alternate 0,1,0,1 three cycles apart
    do_reset();
    for (int c = 0; c < 12; c++) begin
      req0_valid = 1'b1; req1_valid = 1'b1;
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      req0_a = 32'(c); req0_b = 32'd1;
      req1_a = 32'(100 + c); req1_b = 32'(c);
      @(negedge clk);
      check("tie_ready0", 32'(req0_ready), 32'((c % 3 == 0) && ((c / 3) % 2 == 0)));
      check("tie_ready1", 32'(req1_ready), 32'((c % 3 == 0) && ((c / 3) % 2 == 1)));
      check("tie_busy", 32'(busy), 32'(c % 3 != 0));
      next_cycle();
    end
    drain();

    // Backpressure on requester 1 with a zero result; req0 waits, spurious rsp0_ready ignored
    req1_valid = 1'b1; req1_a = 32'd0; req1_b = 32'd0;
    @(negedge clk);
    check("bp_ready1", 32'(req1_ready), 32'd1);
    check("bp_ready0", 32'(req0_ready), 32'd0);
    next_cycle();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd4;
    rsp1_ready = 1'b0; rsp0_ready = 1'b1;
    @(negedge clk);
    check("bp_exec_ready0", 32'(req0_ready), 32'd0);
    for (int c = 0; c < 10; c++) begin
      next_cycle();
      @(negedge clk);
      check("bp_rsp1_valid", 32'(rsp1_valid), 32'd1);
      check("bp_rsp0_valid", 32'(rsp0_valid), 32'd0);
      check("bp_rsp_data", rsp_data, 32'd0);
      check("bp_rsp_zero", 32'(rsp_zero), 32'd1);
      check("bp_hold_ready0", 32'(req0_ready), 32'd0);
    end
    next_cycle();
    rsp1_ready = 1'b1;
    @(negedge clk);
    check("bp_last_rsp1", 32'(rsp1_valid), 32'd1);
    next_cycle();
    rsp1_ready = 1'b0;
    @(negedge clk);
    check("bp_done_busy", 32'(busy), 32'd0);
    check("bp_done_rsp1", 32'(rsp1_valid), 32'd0);
    check("bp_next_ready0", 32'(req0_ready), 32'd1);
    next_cycle();
    drain();

    // Reset during EXEC aborts with no response
    req0_valid = 1'b1; req0_a = 32'd9; req0_b = 32'd9;
    @(negedge clk);
    check("rm_ready0", 32'(req0_ready), 32'd1);
    next_cycle();
    req0_valid = 1'b0;
    @(negedge clk);
    check("rm_exec_busy", 32'(busy), 32'd1);
    do_reset();
    for (int c = 0; c < 5; c++) begin
      rsp0_ready = 1'b1; rsp1_ready = 1'b1;
      @(negedge clk);
      check("rm_no_rsp0", 32'(rsp0_valid), 32'd0);
      check("rm_no_rsp1", 32'(rsp1_valid), 32'd0);
      check("rm_idle", 32'(busy), 32'd0);
      next_cycle();
    end
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;

    // Operand stability after acceptance
    req0_valid = 1'b1; req0_a = 32'd100; req0_b = 32'd23;
    @(negedge clk);
    check("os_ready0", 32'(req0_ready), 32'd1);
    next_cycle();
    req0_valid = 1'b0; req0_a = 32'd7777;
    @(negedge clk);
    check("os_alu_a", alu_a, 32'd100);
    check("os_alu_b", alu_b, 32'd23);
    next_cycle();
    req0_a = 32'd1;
    @(negedge clk);
    check("os_alu_a_resp", alu_a, 32'd100);
    check("os_rsp_data", rsp_data, 32'd123);
    check("os_rsp0_valid", 32'(rsp0_valid), 32'd1);
    next_cycle();
    drain();

    // Withdrawn request: req1 pulses while busy, then a withdrawn tie; last_grant stays 0
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd1;
    @(negedge clk);
    check("wd_ready0", 32'(req0_ready), 32'd1);
    next_cycle();
    req0_valid = 1'b0; req1_valid = 1'b1; req1_a = 32'd50;
    @(negedge clk);
    check("wd_busy_ready1", 32'(req1_ready), 32'd0);
    next_cycle();
    req1_valid = 1'b0; rsp0_ready = 1'b1;
    @(negedge clk);
    check("wd_rsp0_valid", 32'(rsp0_valid), 32'd1);
    check("wd_resp_ready1", 32'(req1_ready), 32'd0);
    next_cycle();
    rsp0_ready = 1'b0;
    @(negedge clk);
    check("wd_idle", 32'(busy), 32'd0);
    check("wd_idle_ready1", 32'(req1_ready), 32'd0);
    next_cycle();
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check("wd_tie_ready1", 32'(req1_ready), 32'd1);
    check("wd_tie_ready0", 32'(req0_ready), 32'd0);
    #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    next_cycle();
    @(negedge clk);
    check("wd_no_accept", 32'(busy), 32'd0);
    next_cycle();
    req0_valid = 1'b1; req0_a = 32'd2; req0_b = 32'd3;
    req1_valid = 1'b1; req1_a = 32'd4; req1_b = 32'd5;
    @(negedge clk);
    check("wd_again_ready1", 32'(req1_ready), 32'd1);
    check("wd_again_ready0", 32'(req0_ready), 32'd0);
    next_cycle();
    drain();

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
